// File: rtl/vga_scan_pkg.sv
// vga_scan_pkg: default 640x480@60 scan timing, the sync bounds derived from
// it, and the coordinate type shared by the scan generator and its helpers.
//   H_* / V_*             default porch/sync/visible widths
//   H_TOTAL / V_TOTAL     line length in pixels, frame length in lines
//   *_SYNC_START / _END   first/last counter value with the sync asserted
//   coord_t               10-bit DrawX/DrawY coordinate
package vga_scan_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int unsigned ANIM_DIV_DEFAULT = 6;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: one register stage on hs/vs so the syncs line up with a
// renderer that registers its RGB one cycle after DrawX/DrawY.
//   i_clk  pixel clock
//   i_rst  asynchronous active-high reset; outputs return to idle-high
//   i_hs   undelayed horizontal sync (active-low)
//   i_vs   undelayed vertical sync (active-low)
//   o_hs   horizontal sync delayed one cycle
//   o_vs   vertical sync delayed one cycle
module vga_sync_delay
  import vga_scan_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hs,
  input  logic i_vs,
  output logic o_hs,
  output logic o_vs
);

  logic r_hs;
  logic r_vs;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hs <= 1'b1;
      r_vs <= 1'b1;
    end else begin
      r_hs <= i_hs;
      r_vs <= i_vs;
    end
  end

  assign o_hs = r_hs;
  assign o_vs = r_vs;

endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: pixel-clock scan generator for the sprite renderers.
// Produces DrawX/DrawY, the visible-region qualifier, active-low syncs,
// line/frame strobes and an animation tick every ANIM_DIV frames.
//   vga_clk      pixel clock, all logic on posedge
//   Reset        asynchronous active-high reset
//   DrawX/DrawY  horizontal / vertical counters
//   blank        1 while the pixel is in the visible region
//   hs / vs      horizontal / vertical sync, active-low
//   line_start   1 when DrawX == 0
//   frame_start  1 when DrawX == 0 and DrawY == 0
//   anim_tick    one-cycle pulse on the frame_start of every ANIM_DIV-th frame
// Build option: define VGA_SYNC_ALIGN_EN to delay hs/vs by one register so
// they align with registered renderer RGB.
module vga_scan_gen #(
  parameter int unsigned H_VISIBLE = vga_scan_pkg::H_VISIBLE,
  parameter int unsigned H_FP      = vga_scan_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_scan_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_scan_pkg::H_BP,
  parameter int unsigned V_VISIBLE = vga_scan_pkg::V_VISIBLE,
  parameter int unsigned V_FP      = vga_scan_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_scan_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_scan_pkg::V_BP,
  parameter int unsigned ANIM_DIV  = vga_scan_pkg::ANIM_DIV_DEFAULT
) (
  input  logic       vga_clk,
  input  logic       Reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic       anim_tick
);

  import vga_scan_pkg::*;

  localparam int unsigned LINE_LEN    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t HC_LAST  = coord_t'(LINE_LEN - 1);
  localparam coord_t VC_LAST  = coord_t'(FRAME_LINES - 1);
  localparam coord_t HC_VIS   = coord_t'(H_VISIBLE);
  localparam coord_t VC_VIS   = coord_t'(V_VISIBLE);
  localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  coord_t     r_hc;
  coord_t     r_vc;
  logic [7:0] r_anim_cnt;
  logic       r_anim_tick;

  logic w_line_end;
  logic w_frame_end;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_blank;
  logic w_line_start;
  logic w_frame_start;

  assign w_line_end  = (r_hc == HC_LAST);
  assign w_frame_end = w_line_end && (r_vc == VC_LAST);

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_line_end) begin
      r_hc <= '0;
      if (r_vc == VC_LAST) r_vc <= '0;
      else                 r_vc <= r_vc + 1'b1;
    end else begin
      r_hc <= r_hc + 1'b1;
    end
  end

  // The divider steps on the last pixel of a frame, so the registered tick
  // lands on the following frame_start cycle.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_anim_cnt  <= '0;
      r_anim_tick <= 1'b0;
    end else begin
      r_anim_tick <= 1'b0;
      if (w_frame_end) begin
        if (r_anim_cnt == ANIM_LAST) begin
          r_anim_cnt  <= '0;
          r_anim_tick <= 1'b1;
        end else begin
          r_anim_cnt <= r_anim_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_blank       = 1'b0;
    w_hs_raw      = 1'b1;
    w_vs_raw      = 1'b1;
    w_line_start  = 1'b0;
    w_frame_start = 1'b0;
    w_blank       = (r_hc < HC_VIS) && (r_vc < VC_VIS);
    w_hs_raw      = !((r_hc >= HS_FIRST) && (r_hc <= HS_LAST));
    w_vs_raw      = !((r_vc >= VS_FIRST) && (r_vc <= VS_LAST));
    w_line_start  = (r_hc == '0);
    w_frame_start = (r_hc == '0) && (r_vc == '0);
  end

`ifdef VGA_SYNC_ALIGN_EN
  vga_sync_delay u_sync_delay (
    .i_clk (vga_clk),
    .i_rst (Reset),
    .i_hs  (w_hs_raw),
    .i_vs  (w_vs_raw),
    .o_hs  (hs),
    .o_vs  (vs)
  );
`else
  assign hs = w_hs_raw;
  assign vs = w_vs_raw;
`endif

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign blank       = w_blank;
  assign line_start  = w_line_start;
  assign frame_start = w_frame_start;
  assign anim_tick   = r_anim_tick;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: checks three scan generators (default 640x480 timing with
// ANIM_DIV=6, and a reduced 25x15 raster with ANIM_DIV=3 and ANIM_DIV=1)
// against a cycle-index model, plus hand-computed milestones.
module tb_vga_scan_gen;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int SYNC_LAT = 1;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic       tick;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  bit   mon = 1'b0;
  int   t = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Cycle index since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  logic [9:0] d_x, d_y, s_x, s_y, o_x, o_y;
  logic d_blank, d_hs, d_vs, d_ls, d_fs, d_tick;
  logic s_blank, s_hs, s_vs, s_ls, s_fs, s_tick;
  logic o_blank, o_hs, o_vs, o_ls, o_fs, o_tick;
  obs_t obs_d, obs_s, obs_o;

  vga_scan_gen u_dut_d (
    .vga_clk(clk), .Reset(rst), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
    .hs(d_hs), .vs(d_vs), .line_start(d_ls), .frame_start(d_fs), .anim_tick(d_tick)
  );

  vga_scan_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .ANIM_DIV(3)
  ) u_dut_s (
    .vga_clk(clk), .Reset(rst), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .line_start(s_ls), .frame_start(s_fs), .anim_tick(s_tick)
  );

  vga_scan_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .ANIM_DIV(1)
  ) u_dut_o (
    .vga_clk(clk), .Reset(rst), .DrawX(o_x), .DrawY(o_y), .blank(o_blank),
    .hs(o_hs), .vs(o_vs), .line_start(o_ls), .frame_start(o_fs), .anim_tick(o_tick)
  );

  assign obs_d = {d_x, d_y, d_blank, d_hs, d_vs, d_ls, d_fs, d_tick};
  assign obs_s = {s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_tick};
  assign obs_o = {o_x, o_y, o_blank, o_hs, o_vs, o_ls, o_fs, o_tick};

  // Expected outputs at cycle t, straight from the raster definition.
  function automatic obs_t model(input int tc, input int hv, input int hfp,
                                 input int hsw, input int hbp, input int vv,
                                 input int vfp, input int vsw, input int vbp,
                                 input int div);
    obs_t o;
    int ht, vt, h, v, f, ts, hp, vp;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    h = tc % ht;
    v = (tc / ht) % vt;
    f = tc / (ht * vt);
    o.x = 10'(h);
    o.y = 10'(v);
    o.blank = (h < hv) && (v < vv);
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    o.tick = (h == 0) && (v == 0) && (f > 0) && (f % div == 0);
    ts = tc - SYNC_LAT;
    if (ts < 0) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      hp = ts % ht;
      vp = (ts / ht) % vt;
      o.hs = !(hp >= hv + hfp && hp < hv + hfp + hsw);
      o.vs = !(vp >= vv + vfp && vp < vv + vfp + vsw);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", nm, t, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input obs_t a, input obs_t e);
    chk({nm, ".DrawX"}, 32'(a.x), 32'(e.x));
    chk({nm, ".DrawY"}, 32'(a.y), 32'(e.y));
    chk({nm, ".blank"}, 32'(a.blank), 32'(e.blank));
    chk({nm, ".hs"}, 32'(a.hs), 32'(e.hs));
    chk({nm, ".vs"}, 32'(a.vs), 32'(e.vs));
    chk({nm, ".line_start"}, 32'(a.ls), 32'(e.ls));
    chk({nm, ".frame_start"}, 32'(a.fs), 32'(e.fs));
    chk({nm, ".anim_tick"}, 32'(a.tick), 32'(e.tick));
  endtask

  always @(negedge clk) begin
    if (mon) begin
      cmp("d", obs_d, model(t, 640, 16, 96, 48, 480, 10, 2, 33, 6));
      cmp("s", obs_s, model(t, 16, 2, 4, 3, 8, 2, 2, 3, 3));
      cmp("o", obs_o, model(t, 16, 2, 4, 3, 8, 2, 2, 3, 1));
    end
  end

  task automatic wait_t(input int target);
    int g;
    g = 0;
    while (t < target && g < 20000) begin
      @(negedge clk);
      g++;
    end
    chk("wait_t", 32'(t), 32'(target));
  endtask

  int hs_low, hs_first, vs_low, tick_s, tick_s1, tick_s2, tick_o, guard;

  initial begin
    rst = 1'b1;
    #1 mon = 1'b1;
    @(negedge clk);
    chk("rst.DrawX", 32'(d_x), 0);
    chk("rst.DrawY", 32'(d_y), 0);
    chk("rst.blank", 32'(d_blank), 1);
    chk("rst.hs", 32'(d_hs), 1);
    chk("rst.vs", 32'(d_vs), 1);
    chk("rst.frame_start", 32'(d_fs), 1);
    chk("rst.anim_tick", 32'(d_tick), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    hs_low = 0; hs_first = -1; vs_low = 0;
    tick_s = 0; tick_s1 = -1; tick_s2 = -1; tick_o = 0; guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (t == 639) chk("d.blank@639", 32'(d_blank), 1);
      if (t == 640) begin
        chk("d.DrawX@640", 32'(d_x), 640);
        chk("d.blank@640", 32'(d_blank), 0);
      end
      if (t == 656) chk("d.hs@656", 32'(d_hs), (SYNC_LAT == 1) ? 1 : 0);
      if (t == 657) chk("d.hs@657", 32'(d_hs), 0);
      if (t == 800) begin
        chk("d.DrawX@800", 32'(d_x), 0);
        chk("d.DrawY@800", 32'(d_y), 1);
        chk("d.line_start@800", 32'(d_ls), 1);
        chk("d.blank@800", 32'(d_blank), 1);
      end
      if (t >= 800 && t < 1600 && d_hs == 1'b0) begin
        if (hs_first < 0) hs_first = int'(d_x);
        hs_low++;
      end
      if (t < 375 && s_vs == 1'b0) vs_low++;
      if (t == 375) begin
        chk("s.DrawX@375", 32'(s_x), 0);
        chk("s.DrawY@375", 32'(s_y), 0);
        chk("s.frame_start@375", 32'(s_fs), 1);
      end
      if (s_tick == 1'b1) begin
        tick_s++;
        if (tick_s == 1) tick_s1 = t;
        if (tick_s == 2) tick_s2 = t;
      end
      if (o_tick == 1'b1) tick_o++;
    end while (t < 2625 && guard < 5000);

    chk("run.end_t", 32'(t), 2625);
    chk("d.hs_low_cycles", 32'(hs_low), 96);
    chk("d.hs_first_low_x", 32'(hs_first), 32'(656 + SYNC_LAT));
    chk("s.vs_low_cycles", 32'(vs_low), 50);
    chk("s.tick_count", 32'(tick_s), 2);
    chk("s.tick1_cycle", 32'(tick_s1), 1125);
    chk("s.tick2_cycle", 32'(tick_s2), 2250);
    chk("o.tick_count", 32'(tick_o), 7);

    // Mid-frame reset on the reduced raster at (10,5) of frame 8.
    wait_t(3135);
    chk("s.DrawX@3135", 32'(s_x), 10);
    chk("s.DrawY@3135", 32'(s_y), 5);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mrst.DrawX", 32'(s_x), 0);
    chk("mrst.DrawY", 32'(s_y), 0);
    chk("mrst.blank", 32'(s_blank), 1);
    chk("mrst.hs", 32'(s_hs), 1);
    chk("mrst.vs", 32'(s_vs), 1);
    chk("mrst.line_start", 32'(s_ls), 1);
    chk("mrst.frame_start", 32'(s_fs), 1);
    chk("mrst.anim_tick", 32'(s_tick), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post.DrawX@0", 32'(s_x), 0);
    @(negedge clk);
    chk("post.DrawX@1", 32'(s_x), 1);
    chk("post.DrawY@1", 32'(s_y), 0);
    wait_t(1124);
    chk("post.anim_tick@1124", 32'(s_tick), 0);
    @(negedge clk);
    chk("post.anim_tick@1125", 32'(s_tick), 1);
    chk("post.DrawX@1125", 32'(s_x), 0);
    chk("post.DrawY@1125", 32'(s_y), 0);
    @(negedge clk);
    chk("post.anim_tick@1126", 32'(s_tick), 0);

    mon = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Pixel-clock scan generator that drives the sprite renderers: produces DrawX/DrawY, the visible-region `blank` qualifier, and the hs/vs syncs for 640x480@60. It also emits per-line/per-frame strobes and a divided animation tick for stepping walk/attack sprite frames. It sits between the pixel clock source and all `*_example` renderers, which consume DrawX/DrawY/blank and return RGB one cycle later.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch (line total 800)
- V_VISIBLE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch (frame total 525)
- ANIM_DIV, 6, frames per anim_tick (legal 1..255)

- vga_clk  in  1  pixel clock (25 MHz), all logic on posedge
- Reset  in  1  asynchronous, active-high
- DrawX  out  10  horizontal counter, 0..799
- DrawY  out  10  vertical counter, 0..524
- blank  out  1  1 = visible pixel (DrawX<640 and DrawY<480)
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- line_start  out  1  1 when DrawX==0
- frame_start  out  1  1 when DrawX==0 and DrawY==0
- anim_tick  out  1  one-cycle pulse every ANIM_DIV frames

## Operation
- hc (DrawX) increments every cycle; at 799 wraps to 0 and vc (DrawY) increments; vc at 524 wraps to 0.
- hs = 0 iff 656 <= hc <= 751; vs = 0 iff 490 <= vc <= 491 (bounds derived from parameters).
- blank, hs, vs, line_start, frame_start: combinational decode of hc/vc registers; no extra latency relative to DrawX/DrawY.
- Animation divider anim_cnt, 8 bits, 0..ANIM_DIV-1: advances on the cycle hc==799 and vc==524 (last pixel of frame); on wrap to 0 anim_tick is asserted the following cycle (coinciding with frame_start). ANIM_DIV=1: anim_tick on every frame_start.
- Reset (any time, mid-frame included): hc=vc=0, anim_cnt=0, delay regs cleared to idle; scan restarts at pixel (0,0) on the first posedge after release.

## Timing
- Reset values: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, line_start=1, frame_start=1, anim_tick=0.
- First post-reset anim_tick: frame_start of frame ANIM_DIV (cycle 800*525*ANIM_DIV after release).
- Line period 800 cycles; frame period 420000 cycles; hs low 96 cycles; vs low 2 lines (1600 cycles).
- Renderer contract: renderer registers RGB one cycle after DrawX; syncs must follow per Configuration.

## Configuration
- VGA_SYNC_ALIGN_EN defined: hs and vs each pass through one register (reset value 1) so they align with the renderer's registered RGB; blank, DrawX/DrawY, strobes unchanged. hs falls at the cycle after hc==656.
- Not defined: hs/vs undelayed, falling in the cycle hc==656 / vc==490 begins.

## Structure
- Package vga_scan_pkg: default timing constants (H_*/V_* values, H_TOTAL=800, V_TOTAL=525), derived sync start/end localparams, 10-bit coord typedef.
- Sub-module vga_sync_delay: one-stage reset-to-1 register for hs/vs, instantiated only under VGA_SYNC_ALIGN_EN.

## Test plan
- Reset released at cycle 0 -> DrawX counts 0..799, DrawY steps to 1 at cycle 800; blank falls at DrawX=640, rises at DrawX=0 of next line.
- hs probe over one line -> exactly 96 low cycles, first low when DrawX=656 (657 with VGA_SYNC_ALIGN_EN).
- Full frame run -> vs low 1600 cycles starting DrawY=490; DrawY wraps 524->0 with frame_start at cycle 420000.
- ANIM_DIV=3, run 7 frames -> anim_tick pulses exactly at cycles 1260000 and 2520000, width 1.
- Assert Reset at DrawX=300, DrawY=200 for 3 cycles -> outputs at reset values during assertion; scan resumes from (0,0); anim_cnt restarted.
- ANIM_DIV=1 -> anim_tick coincides with every frame_start.
